mix_columns_seq: RTL
====================

Name: mix_columns_seq

Overview:
- Sequential, handshaked AES MixColumns / InvMixColumns engine.
- Processes a 128-bit state COLS_PER_CYCLE columns per clock.
- Forward or inverse mode is selected per transaction.
- Sits between ShiftRows/InvSubBytes and AddRoundKey in the round datapath. Replaces the fixed combinational inverse-only mixer with a single shared, throttled unit for both encrypt and decrypt.

Parameters:
- COLS_PER_CYCLE, 1, columns mixed per BUSY cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- RED_POLY, 8'h1B, low byte of the GF(2^8) reduction polynomial x^8+x^4+x^3+x+1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input state presented
- in_ready  out  1  unit can accept a state
- in_state  in  128  column c at bits [32c+31:32c]; row 0 is the top byte of each column
- in_inverse  in  1  0 = MixColumns, 1 = InvMixColumns; sampled only at accept
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_state  out  128  mixed state, same layout as in_state
- busy  out  1  high in BUSY or DONE

Behaviour:
- Reset, sampled at a clk edge with reset=1:
  - FSM goes to IDLE; column counter = 0; mode register = 0.
  - out_state = 0, out_valid = 0.
  - in_ready = 0 during any cycle where reset is high; in_ready = 1 in IDLE otherwise.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - An edge with in_valid & in_ready latches in_state into the work register, latches in_inverse into the mode register, clears the counter, and goes to BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle mixes columns [cnt*C .. cnt*C+C-1] from the work register into the matching slices of the result register, then cnt += 1.
  - After the 4/C-th group completes, go to DONE.
  - The counter is 2 bits wide; it never wraps within a transaction because it is cleared on entry.
- DONE:
  - out_valid = 1; out_state = result register, held stable.
  - An edge with out_ready = 1 returns to IDLE; out_valid drops on that edge.
  - A new input cannot be accepted in the same cycle as the DONE->IDLE transition. in_ready rises the following cycle, so there is one bubble per transaction.
- Latency: accept at edge k gives out_valid high after edge k+4/C, i.e. 4, 2 or 1 BUSY cycles.
- Throughput: one state per 4/C+2 cycles with out_ready held high.
- Backpressure: while out_ready = 0 in DONE, out_state and out_valid hold indefinitely. in_valid and in_state are ignored.
- Changes to in_state or in_inverse after accept have no effect on the transaction in flight.
- Reset mid-BUSY or mid-DONE aborts the transaction. No output is produced, and the result register is zeroed.
- Arithmetic is all in GF(2^8):
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? RED_POLY : 0).
  - Multiply by 3 = xtime ^ b.
  - Multiply by 9, b, d, e are built from three xtime steps plus xors.
  - Additions are xor, 8-bit, with no carries.
- Forward matrix rows: [2 3 1 1], [1 2 3 1], [1 1 2 3], [3 1 1 2].
- Inverse matrix rows: [e b d 9], [9 e b d], [d 9 e b], [b d 9 e].
- Output row r of a column = xor over j of M[r][j]·a_j, where a_0 is the top byte.

Decomposition:
- Package aes_gf_pkg holds:
  - RED_POLY default constant.
  - xtime function and gf_mul_const function (constant multipliers 1, 2, 3, 9, b, d, e).
  - Column slice-index helper function.
  - FSM state encoding constants.
- Sub-module gf_mix_column: purely combinational, one 32-bit column in/out plus an inverse select. It is instantiated COLS_PER_CYCLE times; the column mux and FSM live in the top.

Test Plan:
- Forward mix, C=1: in_state=128'h2d26314c_01010101_f20a225c_db135345 with in_inverse=0 -> out_state=128'h4d7ebdf8_01010101_9fdc589d_8e4da1bc. out_valid rises exactly 4 cycles after accept.
- Inverse mix, C=4: in_state=128'h4d7ebdf8_01010101_9fdc589d_8e4da1bc with in_inverse=1 -> 128'h2d26314c_01010101_f20a225c_db135345. Latency is 1 cycle.
- Special columns, C=2: columns c6c6c6c6 and d4d4d4d5 forward -> c6c6c6c6 and d5d5d7d6. Then inverse of d5d5d7d6 -> d4d4d4d5.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_state stable, out_valid=1, in_ready=0. A new in_valid pulse during DONE is ignored. Releasing out_ready gives exactly one output, and in_ready returns one cycle later.
- Reset mid-BUSY: assert reset 2 cycles after accept (C=1) -> next cycle out_valid=0, out_state=0, busy=0, and no spurious output afterwards. The next transaction completes correctly.
- Randomized: 1000 random states and modes per C value compared against a reference model. forward∘inverse must be the identity on every state.

Source files
------------

// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers and shared encodings for the AES MixColumns engine.
// Constant multipliers are built from xtime chains so no general multiplier is inferred.
package aes_gf_pkg;

    localparam logic [7:0] RED_POLY_DEFAULT = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mix_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b, input logic [7:0] poly);
        return {b[6:0], 1'b0} ^ (b[7] ? poly : 8'h00);
    endfunction

    // Multiply by one of the MixColumns constants {1,2,3,9,b,d,e}.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] b,
                                                input logic [3:0] k,
                                                input logic [7:0] poly);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] r;
        x2 = xtime(b, poly);
        x4 = xtime(x2, poly);
        x8 = xtime(x4, poly);
        case (k)
            4'h1:    r = b;
            4'h2:    r = x2;
            4'h3:    r = x2 ^ b;
            4'h9:    r = x8 ^ b;
            4'hb:    r = x8 ^ x2 ^ b;
            4'hd:    r = x8 ^ x4 ^ b;
            4'he:    r = x8 ^ x4 ^ x2;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Bit offset of column `col` inside a 128-bit state.
    function automatic logic [6:0] col_lsb(input logic [1:0] col);
        return {col, 5'b00000};
    endfunction

endpackage

// File: rtl/gf_mix_column.sv
// Combinational mixer for one 32-bit column; row 0 is the top byte.
// inverse selects the InvMixColumns matrix instead of the forward one.
module gf_mix_column
    import aes_gf_pkg::*;
#(
    parameter logic [7:0] RED_POLY = RED_POLY_DEFAULT
) (
    input  logic [31:0] col_in,
    input  logic        inverse,
    output logic [31:0] col_out
);

    // Both matrices are circulant: row r is the base row rotated right by r.
    localparam logic [3:0] FWD_COEF [4] = '{4'h2, 4'h3, 4'h1, 4'h1};
    localparam logic [3:0] INV_COEF [4] = '{4'he, 4'hb, 4'hd, 4'h9};

    always_comb begin
        // NOTE: every bit gets a value before any conditional logic, so no latch can be inferred.
        col_out = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                col_out[31-8*r -: 8] ^= gf_mul_const(col_in[31-8*j -: 8],
                                                     inverse ? INV_COEF[2'(j - r)]
                                                             : FWD_COEF[2'(j - r)],
                                                     RED_POLY);
            end
        end
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Handshaked, throttled AES MixColumns/InvMixColumns engine: IDLE -> BUSY (4/C cycles) -> DONE.
// COLS_PER_CYCLE column mixers are shared across the column groups of the captured state.
module mix_columns_seq
    import aes_gf_pkg::*;
#(
    parameter int         COLS_PER_CYCLE = 1,
    parameter logic [7:0] RED_POLY       = RED_POLY_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam int         GROUPS     = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_GROUP = 2'(GROUPS - 1);

    mix_state_t   state;
    logic [1:0]   cnt;
    logic         inverse_q;
    logic [127:0] work;
    logic [127:0] result;

    logic [1:0]   col_idx [COLS_PER_CYCLE];
    logic [31:0]  mix_out [COLS_PER_CYCLE];

    logic accept;
    assign accept = in_valid && in_ready;

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_idx[g] = 2'(int'(cnt) * COLS_PER_CYCLE + g);

        gf_mix_column #(
            .RED_POLY (RED_POLY)
        ) u_mix (
            .col_in  (work[col_lsb(col_idx[g]) +: 32]),
            .inverse (inverse_q),
            .col_out (mix_out[g])
        );
    end

    // NOTE: the work register is pure data, only read in BUSY after a load, so it has no reset.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && in_valid && !reset) begin
            work <= in_state;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 2'd0;
            inverse_q <= 1'b0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        inverse_q <= in_inverse;
                        cnt       <= 2'd0;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                        result[col_lsb(col_idx[i]) +: 32] <= mix_out[i];
                    end
                    cnt <= cnt + 2'd1;
                    if (cnt == LAST_GROUP) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Gated by reset so nothing is accepted on the same edge the FSM is being cleared.
    assign in_ready  = (state == ST_IDLE) && !reset;
    assign busy      = (state != ST_IDLE);
    assign out_state = result;

endmodule
